// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode constants: requester count, formats, units, payload layout
package decode_pkg;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_PAYLOAD_W = 200;
  localparam int DEF_MAJ_ID_W  = 64;
  localparam int DEF_PTR_W     = 2;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
  localparam int REQ_D = 2;

  localparam logic [7:0] FMT_I  = 8'b0000_0001;
  localparam logic [7:0] FMT_B  = 8'b0000_0010;
  localparam logic [7:0] FMT_XL = 8'b0000_0100;
  localparam logic [7:0] FMT_D  = 8'b0000_1000;
  localparam logic [7:0] FMT_DS = 8'b0001_0000;
  localparam logic [7:0] FMT_X  = 8'b0010_0000;
  localparam logic [7:0] FMT_XO = 8'b0100_0000;
  localparam logic [7:0] FMT_M  = 8'b1000_0000;

  typedef enum logic [2:0] {
    UNIT_FX = 3'd0,
    UNIT_FP = 3'd1,
    UNIT_VX = 3'd2,
    UNIT_CR = 3'd3,
    UNIT_LS = 3'd4,
    UNIT_BR = 3'd6
  } unit_e;

  typedef enum logic [1:0] {
    REG_RD_NONE = 2'd0,
    REG_RD_GPR  = 2'd1,
    REG_RD_FPR  = 2'd2,
    REG_RD_VR   = 2'd3
  } reg_read_e;

  typedef enum logic [1:0] {
    REG_WR_NONE = 2'd0,
    REG_WR_GPR  = 2'd1,
    REG_WR_FPR  = 2'd2,
    REG_WR_VR   = 2'd3
  } reg_write_e;

  // Payload packing, LSB first; the widths sum to DEF_PAYLOAD_W.
  localparam int OPC_W    = 6;
  localparam int ADDR_W   = 64;
  localparam int UNIT_W   = 3;
  localparam int INS_ID_W = 16;
  localparam int PID_W    = 8;
  localparam int TID_W    = 8;
  localparam int REGRD_W  = 2;
  localparam int REGWR_W  = 2;
  localparam int OPND_W   = 45;
  localparam int BODY_W   = 46;

  localparam int OPC_OFF    = 0;
  localparam int ADDR_OFF   = OPC_OFF + OPC_W;
  localparam int UNIT_OFF   = ADDR_OFF + ADDR_W;
  localparam int INS_ID_OFF = UNIT_OFF + UNIT_W;
  localparam int PID_OFF    = INS_ID_OFF + INS_ID_W;
  localparam int TID_OFF    = PID_OFF + PID_W;
  localparam int REGRD_OFF  = TID_OFF + TID_W;
  localparam int REGWR_OFF  = REGRD_OFF + REGRD_W;
  localparam int OPND_OFF   = REGWR_OFF + REGWR_W;
  localparam int BODY_OFF   = OPND_OFF + OPND_W;
  localparam int PAYLOAD_SUM_W = BODY_OFF + BODY_W;

endpackage

// File: rtl/decode_format_arbiter_rr_picker.sv
// rtl/decode_format_arbiter_rr_picker.sv - rr_picker: one-hot round-robin pick of a request vector
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // First pass covers indices at or above ptr, second pass wraps to the low indices.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (PTR_W'(j) >= ptr)) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_format_arbiter.sv
// rtl/decode_format_arbiter.sv - holding buffers + arbiter sharing the decode-to-issue slot
// DECODE_ARB_AGE_PRIORITY_EN selects oldest-majId priority instead of round-robin.
module decode_format_arbiter
  import decode_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int MAJ_ID_W  = DEF_MAJ_ID_W,
  parameter int PTR_W     = DEF_PTR_W
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            reqValid_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]  reqPayload_i,
  input  logic [NUM_REQ*MAJ_ID_W-1:0]   reqMajId_i,
  output logic [NUM_REQ-1:0]            reqReady_o,
  input  logic                          stall_i,
  output logic                          enable_o,
  output logic [PAYLOAD_W-1:0]          payload_o,
  output logic [MAJ_ID_W-1:0]           majId_o,
  output logic [NUM_REQ-1:0]            grant_o
);

  logic [NUM_REQ-1:0]   held;
  logic [PAYLOAD_W-1:0] held_payload [NUM_REQ];
  logic [MAJ_ID_W-1:0]  held_maj_id  [NUM_REQ];
  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   pick;
  logic [NUM_REQ-1:0]   grant_now;
  logic                 out_free;
  logic                 grant_any;
  logic [PTR_W-1:0]     win_idx;
  logic [PAYLOAD_W-1:0] win_payload;
  logic [MAJ_ID_W-1:0]  win_maj_id;

  assign out_free = !enable_o || !stall_i;

`ifdef DECODE_ARB_AGE_PRIORITY_EN
  // Strict less-than while scanning upward keeps ties on the lowest index.
  always_comb begin
    logic                found;
    logic [MAJ_ID_W-1:0] best_id;
    pick    = '0;
    found   = 1'b0;
    best_id = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (held[j] && (!found || held_maj_id[j] < best_id)) begin
        pick    = '0;
        pick[j] = 1'b1;
        found   = 1'b1;
        best_id = held_maj_id[j];
      end
    end
  end
`else
  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req   (held),
    .ptr   (rr_ptr),
    .grant (pick)
  );
`endif

  assign grant_now  = out_free ? pick : '0;
  assign grant_any  = |grant_now;
  assign reqReady_o = ~held | grant_now;

  always_comb begin
    win_idx     = '0;
    win_payload = '0;
    win_maj_id  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_now[j]) begin
        win_idx     = PTR_W'(j);
        win_payload = held_payload[j];
        win_maj_id  = held_maj_id[j];
      end
    end
  end

  // Entry data needs no reset: held[] alone says whether a slot is meaningful.
  always_ff @(posedge clock_i) begin
    for (int j = 0; j < NUM_REQ; j++) begin
      if (reqValid_i[j] && reqReady_o[j]) begin
        held_payload[j] <= reqPayload_i[j*PAYLOAD_W +: PAYLOAD_W];
        held_maj_id[j]  <= reqMajId_i[j*MAJ_ID_W +: MAJ_ID_W];
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      held      <= '0;
      rr_ptr    <= '0;
      enable_o  <= 1'b0;
      payload_o <= '0;
      majId_o   <= '0;
      grant_o   <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (reqValid_i[j] && reqReady_o[j]) begin
          held[j] <= 1'b1;
        end else if (grant_now[j]) begin
          held[j] <= 1'b0;
        end
      end
      if (grant_any) begin
        enable_o  <= 1'b1;
        payload_o <= win_payload;
        majId_o   <= win_maj_id;
        grant_o   <= grant_now;
        rr_ptr    <= (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);
      end else if (out_free) begin
        enable_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_format_arbiter.sv
// tb/tb_decode_format_arbiter.sv - directed self-checking bench for decode_format_arbiter
module tb_decode_format_arbiter;

  localparam int N    = 3;
  localparam int PW   = 200;
  localparam int MW   = 64;
  localparam int PTRW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*PW-1:0]   req_payload = '0;
  logic [N*MW-1:0]   req_maj_id = '0;
  logic [N-1:0]      req_ready;
  logic              stall = 1'b0;
  logic              enable;
  logic [PW-1:0]     payload;
  logic [MW-1:0]     maj_id;
  logic [N-1:0]      grant;

  int checks   = 0;
  int failures = 0;

  decode_format_arbiter #(
    .NUM_REQ   (N),
    .PAYLOAD_W (PW),
    .MAJ_ID_W  (MW),
    .PTR_W     (PTRW)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .reqValid_i   (req_valid),
    .reqPayload_i (req_payload),
    .reqMajId_i   (req_maj_id),
    .reqReady_o   (req_ready),
    .stall_i      (stall),
    .enable_o     (enable),
    .payload_o    (payload),
    .majId_o      (maj_id),
    .grant_o      (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [PW-1:0] p, input logic [MW-1:0] m);
    req_valid[i]          = v;
    req_payload[i*PW +: PW] = p;
    req_maj_id[i*MW +: MW]  = m;
  endtask

  task automatic do_reset();
    req_valid = '0;
    stall     = 1'b0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
  endtask

  logic [N-1:0]  exp_g [4];
  logic [MW-1:0] exp_m [4];

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_enable",  enable,    1'b0);
    check("rst_grant",   grant,     3'b000);
    check("rst_payload", payload,   '0);
    check("rst_ready",   req_ready, 3'b111);

    // Reset pulse between edges while A sits stalled in the output stage
    drive(0, 1'b1, 200'h11, 64'd1);
    stall = 1'b1;
    step();
    drive(0, 1'b0, '0, '0);
    check("t1_accept_enable", enable, 1'b0);
    step();
    check("t1_enable", enable, 1'b1);
    check("t1_grant",  grant,  3'b001);
    #1;
    rst = 1'b1;
    #1;
    check("t1_rst_enable",  enable,    1'b0);
    check("t1_rst_grant",   grant,     3'b000);
    check("t1_rst_ready",   req_ready, 3'b111);
    check("t1_rst_maj",     maj_id,    64'd0);
    rst   = 1'b0;
    stall = 1'b0;

    // Single request: 1-cycle latency through the holding buffer
    drive(0, 1'b1, 200'hABC, 64'd5);
    #1;
    check("t2_ready", req_ready, 3'b111);
    step();
    drive(0, 1'b0, '0, '0);
    check("t2_lat_enable", enable, 1'b0);
    step();
    check("t2_enable",  enable,  1'b1);
    check("t2_grant",   grant,   3'b001);
    check("t2_maj",     maj_id,  64'd5);
    check("t2_payload", payload, 200'hABC);
    step();
    check("t2_drain_enable", enable, 1'b0);
    check("t2_keep_grant",   grant,  3'b001);
    check("t2_keep_maj",     maj_id, 64'd5);

    // Contention: all three valid every cycle
    do_reset();
    drive(0, 1'b1, 200'hA0, 64'd10);
    drive(1, 1'b1, 200'hB0, 64'd20);
    drive(2, 1'b1, 200'hD0, 64'd30);
    step();
    exp_g[0] = 3'b001; exp_m[0] = 64'd10;
    exp_g[1] = 3'b010; exp_m[1] = 64'd20;
    exp_g[2] = 3'b100; exp_m[2] = 64'd30;
    exp_g[3] = 3'b001; exp_m[3] = 64'd10;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_ready_%0d", k), req_ready, exp_g[k]);
      step();
      check($sformatf("t3_grant_%0d", k), grant,  exp_g[k]);
      check($sformatf("t3_maj_%0d", k),   maj_id, exp_m[k]);
      check($sformatf("t3_en_%0d", k),    enable, 1'b1);
    end

    // Stall holds the output while B and D fill, then drains in RR order
    do_reset();
    drive(0, 1'b1, 200'h77, 64'd7);
    step();
    drive(0, 1'b0, '0, '0);
    step();
    check("t4_out_maj", maj_id, 64'd7);
    stall = 1'b1;
    drive(1, 1'b1, 200'h88, 64'd8);
    drive(2, 1'b1, 200'h99, 64'd9);
    #1;
    check("t4_ready_empty", req_ready, 3'b111);
    step();
    drive(1, 1'b0, '0, '0);
    drive(2, 1'b0, '0, '0);
    #1;
    check("t4_ready_full", req_ready, 3'b001);
    check("t4_maj_s1",     maj_id,    64'd7);
    step();
    step();
    check("t4_maj_s3",     maj_id,  64'd7);
    check("t4_payload_s3", payload, 200'h77);
    check("t4_enable_s3",  enable,  1'b1);
    check("t4_grant_s3",   grant,   3'b001);
    stall = 1'b0;
    #1;
    check("t4_ready_unstall", req_ready, 3'b011);
    step();
    check("t4_drain_b_grant", grant,   3'b010);
    check("t4_drain_b_maj",   maj_id,  64'd8);
    step();
    check("t4_drain_d_grant", grant,   3'b100);
    check("t4_drain_d_maj",   maj_id,  64'd9);
    check("t4_drain_d_pay",   payload, 200'h99);
    step();
    check("t4_idle", enable, 1'b0);

`ifdef DECODE_ARB_AGE_PRIORITY_EN
    // Age priority: smallest majId first, ties to the lowest index
    do_reset();
    drive(0, 1'b1, 200'hA9, 64'd9);
    drive(1, 1'b1, 200'hB3, 64'd3);
    drive(2, 1'b1, 200'hD3, 64'd3);
    step();
    req_valid = '0;
    step();
    check("t5_grant_0", grant, 3'b010);
    step();
    check("t5_grant_1", grant, 3'b100);
    step();
    check("t5_grant_2", grant,  3'b001);
    check("t5_maj_2",   maj_id, 64'd9);
`endif

    // Back-to-back from A: no bubbles
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 200'h600 + 200'(k), 64'd100 + 64'(k));
      #1;
      check($sformatf("t6_ready_%0d", k), req_ready[0], 1'b1);
      step();
      if (k >= 1) begin
        check($sformatf("t6_en_%0d", k),  enable, 1'b1);
        check($sformatf("t6_maj_%0d", k), maj_id, 64'd100 + 64'(k - 1));
      end
    end
    drive(0, 1'b0, '0, '0);
    step();
    check("t6_en_last",  enable,  1'b1);
    check("t6_maj_last", maj_id,  64'd103);
    check("t6_pay_last", payload, 200'h603);
    step();
    check("t6_idle", enable, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
